// File: rtl/spi_flash_reader.sv
// rtl/spi_flash_reader.sv - byte-read front end issuing 0x03 READ sequences through spi_core
// Optional feature macro: SPI_FLASH_CONTINUOUS_EN (keep cs_n low and stream sequential reads)
module spi_flash_reader #(
    parameter logic [7:0] READ_CMD    = 8'h03,
    parameter logic [7:0] INIT_CMD    = 8'hAB,
    parameter int         CS_HIGH_CYC = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic [23:0] req_addr_i,
    output logic        req_ready_o,
    output logic [7:0]  rdata_o,
    output logic        rdata_valid_o,
    output logic        init_done_o,
    output logic        spi_cs_n_o,
    output logic [7:0]  spi_data_tx_o,
    output logic        spi_txn_start_o,
    input  logic        spi_txn_done_i,
    input  logic [7:0]  spi_data_rx_i
);
    localparam int            GW       = (CS_HIGH_CYC > 1) ? $clog2(CS_HIGH_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_HIGH_CYC - 1);

    typedef enum logic [3:0] {
        S_CS_GAP, S_INIT, S_IDLE, S_CMD, S_A2, S_A1, S_A0, S_DATA, S_STREAM
    } state_t;

    // Per-byte handshake: SETUP holds one cycle after cs_n falls, ISSUE pulses start,
    // SKIP ignores the stale done flag, WAIT samples the received byte.
    typedef enum logic [1:0] {PH_ISSUE, PH_SKIP, PH_WAIT, PH_SETUP} phase_t;

    state_t        state_q, state_d, ret_q, ret_d;
    phase_t        phase_q, phase_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [23:0]   addr_q, addr_d;
    logic          cs_n_q, cs_n_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          rdata_valid_q, rdata_valid_d;
    logic          init_done_q, init_done_d;
    logic [7:0]    tx_byte;
    logic          in_xfer;
    logic          xfer_done;

    // State register with synchronous reset; reset restarts the INIT sequence behind a cs_n gap
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_CS_GAP;
            ret_q         <= S_INIT;
            phase_q       <= PH_ISSUE;
            gap_q         <= '0;
            addr_q        <= '0;
            cs_n_q        <= 1'b1;
            rdata_q       <= 8'h00;
            rdata_valid_q <= 1'b0;
            init_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ret_q         <= ret_d;
            phase_q       <= phase_d;
            gap_q         <= gap_d;
            addr_q        <= addr_d;
            cs_n_q        <= cs_n_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            init_done_q   <= init_done_d;
        end
    end

    // Next-state, byte handshake and combinational spi_core/CPU outputs
    always_comb begin
        state_d         = state_q;
        ret_d           = ret_q;
        phase_d         = phase_q;
        gap_d           = gap_q;
        addr_d          = addr_q;
        cs_n_d          = cs_n_q;
        rdata_d         = rdata_q;
        rdata_valid_d   = 1'b0;
        init_done_d     = init_done_q;
        req_ready_o     = 1'b0;
        spi_txn_start_o = 1'b0;
        spi_data_tx_o   = 8'h00;
        xfer_done       = 1'b0;
        tx_byte         = 8'h00;
        in_xfer         = 1'b1;

        case (state_q)
            S_INIT:  tx_byte = INIT_CMD;
            S_CMD:   tx_byte = READ_CMD;
            S_A2:    tx_byte = addr_q[23:16];
            S_A1:    tx_byte = addr_q[15:8];
            S_A0:    tx_byte = addr_q[7:0];
            S_DATA:  tx_byte = 8'h00;
            default: in_xfer = 1'b0;
        endcase

        if (in_xfer) begin
            spi_data_tx_o = tx_byte;
            case (phase_q)
                PH_SETUP: phase_d = PH_ISSUE;
                PH_ISSUE: begin
                    if (spi_txn_done_i) begin
                        spi_txn_start_o = 1'b1;
                        phase_d         = PH_SKIP;
                    end
                end
                PH_SKIP:  phase_d = PH_WAIT;
                default: begin
                    if (spi_txn_done_i) begin
                        xfer_done = 1'b1;
                        phase_d   = PH_ISSUE;
                    end
                end
            endcase
        end

        case (state_q)
            S_CS_GAP: begin
                // First cycle raises cs_n; the counter only runs once cs_n is actually high
                cs_n_d = 1'b1;
                if (cs_n_q) begin
                    if (gap_q == GAP_LAST) begin
                        gap_d   = '0;
                        state_d = ret_q;
                        if (ret_q != S_IDLE) begin
                            cs_n_d  = 1'b0;
                            phase_d = PH_SETUP;
                        end
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
            end
            S_INIT: begin
                if (xfer_done) begin
                    init_done_d = 1'b1;
                    state_d     = S_CS_GAP;
                    ret_d       = S_IDLE;
                end
            end
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    cs_n_d  = 1'b0;
                    phase_d = PH_SETUP;
                    state_d = S_CMD;
                end
            end
            S_CMD: if (xfer_done) state_d = S_A2;
            S_A2:  if (xfer_done) state_d = S_A1;
            S_A1:  if (xfer_done) state_d = S_A0;
            S_A0:  if (xfer_done) state_d = S_DATA;
            S_DATA: begin
                if (xfer_done) begin
                    rdata_d       = spi_data_rx_i;
                    rdata_valid_d = 1'b1;
`ifdef SPI_FLASH_CONTINUOUS_EN
                    state_d       = S_STREAM;
`else
                    state_d       = S_CS_GAP;
                    ret_d         = S_IDLE;
`endif
                end
            end
`ifdef SPI_FLASH_CONTINUOUS_EN
            S_STREAM: begin
                // Flash keeps auto-incrementing while cs_n stays low; only the next address streams
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_d = req_addr_i;
                    if (req_addr_i == addr_q + 24'd1) begin
                        state_d = S_DATA;
                        phase_d = PH_ISSUE;
                    end else begin
                        cs_n_d  = 1'b1;
                        state_d = S_CS_GAP;
                        ret_d   = S_CMD;
                    end
                end
            end
`endif
            default: state_d = S_CS_GAP;
        endcase
    end

    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign init_done_o   = init_done_q;
    assign spi_cs_n_o    = cs_n_q;

endmodule
